// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Turns a valid/ready instruction stream into the fixed write sequence of the
//   cpuCore debug instruction port. The core stays in reset while the program
//   is written and is released in the cycle after the final write.
//
//   Each word: handshake (ACCEPT) -> SETTLE_CYCLES of stable address/data
//   (SETTLE) -> one-cycle write strobe (WRITE). If in_last has not been seen
//   after MAX_WORDS writes, the loader parks in ERROR with the core held in reset.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   load_start          start or restart a load (honoured in IDLE/RUN/ERROR)
//   in_valid/in_ready   stream handshake; in_instr data; in_last marks the final word
//   dbg_wr_en/addr/instr  cpuCore debug instruction write port
//   core_rst            reset to cpuCore (active-high)
//   busy, done, overflow_err, word_count   status
module imem_program_loader #(
    parameter int               XLEN               = 64,
    parameter int               INSTRUCTION_LENGTH = XLEN / 2,
    parameter logic [XLEN-1:0]  BASE_ADDR          = '0,
    parameter int               MAX_WORDS          = 1024,
    parameter int               SETTLE_CYCLES      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0]   in_instr,
    input  logic                            in_last,
    output logic                            dbg_wr_en,
    output logic [XLEN-1:0]                 dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0]   dbg_instr,
    output logic                            core_rst,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow_err,
    output logic [$clog2(MAX_WORDS+1)-1:0]  word_count
);

    localparam int WCW         = $clog2(MAX_WORDS + 1);
    localparam int SCW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // The counter is loaded at the handshake and WRITE follows the cycle in
    // which it reads zero, so loading N-1 gives exactly N settle cycles.
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SETTLE,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                          state, state_nx;
    logic [SCW-1:0]                  settle_cnt, settle_cnt_nx;
    logic                            last_q, last_nx;
    logic [XLEN-1:0]                 addr_nx;
    logic [INSTRUCTION_LENGTH-1:0]   instr_nx;
    logic [WCW-1:0]                  wc_nx;

    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        last_nx       = last_q;
        addr_nx       = dbg_addr;
        instr_nx      = dbg_instr;
        wc_nx         = word_count;

        case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_start) begin
                    state_nx = S_ACCEPT;
                    addr_nx  = BASE_ADDR;
                    wc_nx    = '0;
                end
            end
            S_ACCEPT: begin
                if (in_valid && in_ready) begin
                    instr_nx      = in_instr;
                    last_nx       = in_last;
                    settle_cnt_nx = SCW'(SETTLE_LOAD);
                    state_nx      = (SETTLE_CYCLES > 0) ? S_SETTLE : S_WRITE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nx = S_WRITE;
                end else begin
                    settle_cnt_nx = settle_cnt - 1'b1;
                end
            end
            S_WRITE: begin
                wc_nx = word_count + 1'b1;
                // in_last on the MAX_WORDS-th word still counts as a clean finish.
                if (last_q) begin
                    state_nx = S_RUN;
                end else if (wc_nx == MAX_CNT) begin
                    state_nx = S_ERROR;
                end else begin
                    addr_nx  = dbg_addr + XLEN'(4);
                    state_nx = S_ACCEPT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered copies of decodes of the next state, so each
    // output is valid in the same cycle as the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            last_q       <= 1'b0;
            dbg_addr     <= BASE_ADDR;
            dbg_instr    <= '0;
            word_count   <= '0;
            in_ready     <= 1'b0;
            dbg_wr_en    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            core_rst     <= 1'b1;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_cnt_nx;
            last_q       <= last_nx;
            dbg_addr     <= addr_nx;
            dbg_instr    <= instr_nx;
            word_count   <= wc_nx;
            in_ready     <= (state_nx == S_ACCEPT);
            dbg_wr_en    <= (state_nx == S_WRITE);
            busy         <= (state_nx == S_ACCEPT) || (state_nx == S_SETTLE) ||
                            (state_nx == S_WRITE);
            done         <= (state_nx == S_RUN);
            overflow_err <= (state_nx == S_ERROR);
            core_rst     <= (state_nx != S_RUN);
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader (MAX_WORDS=4, SETTLE_CYCLES=2, BASE_ADDR=0).
// The reference model is a queue of expected writes: the word at stream index k
// goes to BASE + 4*k, and its strobe lands exactly 1+SETTLE cycles after the handshake.
module tb_imem_program_loader;

    localparam int          XLEN   = 64;
    localparam int          IL     = 32;
    localparam int          MAXW   = 4;
    localparam int          SETTLE = 2;
    localparam logic [63:0] BASE   = 64'h0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [IL-1:0]   in_instr = '0;
    logic            in_ready, dbg_wr_en, core_rst, busy, done, overflow_err;
    logic [XLEN-1:0] dbg_addr;
    logic [IL-1:0]   dbg_instr;
    logic [2:0]      word_count;

    imem_program_loader #(
        .XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
        .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
        .core_rst(core_rst), .busy(busy), .done(done),
        .overflow_err(overflow_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          hs;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_writes = 0;
    logic [63:0] next_addr = BASE;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: a pending (handshaken, not yet written) word must be
    // presented stably with in_ready low, and strobed exactly once on time.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_write_exclusive", in_ready & dbg_wr_en, 0);
            if (dbg_wr_en) n_writes++;
            if (exp_q.size() > 0 && cyc > exp_q[0].hs) begin
                chk("pending_no_ready", in_ready, 0);
                chk("pending_core_rst", core_rst, 1);
                chk("pending_addr", dbg_addr, exp_q[0].addr);
                chk("pending_instr", dbg_instr, exp_q[0].data);
                chk("write_timing", dbg_wr_en, cyc == exp_q[0].hs + 1 + SETTLE);
                if (cyc >= exp_q[0].hs + 1 + SETTLE) void'(exp_q.pop_front());
            end else begin
                chk("write_unexpected", dbg_wr_en, 0);
            end
        end
    end

    task automatic do_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        next_addr  = BASE;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input int gap,
                             input int budget, input bit noise, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < gap; i++) begin
            load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        load_start = 1'b0;
        in_valid = 1'b1;
        in_instr = d;
        in_last  = last;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                exp_q.push_back('{addr: next_addr, data: d, hs: cyc});
                next_addr += 64'd4;
            end else begin
                chk("load_core_rst", core_rst, 1);
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_core_rst"}, core_rst, 1);
        chk({p, "_wr_en"}, dbg_wr_en, 0);
        chk({p, "_addr"}, dbg_addr, BASE);
        chk({p, "_instr"}, dbg_instr, 0);
        chk({p, "_ready"}, in_ready, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_ovf"}, overflow_err, 0);
        chk({p, "_wc"}, word_count, 0);
    endtask

    task automatic check_end(input string p, input bit run, input int wc);
        chk({p, "_done"}, done, run);
        chk({p, "_core_rst"}, core_rst, !run);
        chk({p, "_ovf"}, overflow_err, !run);
        chk({p, "_wc"}, word_count, wc);
        chk({p, "_ready"}, in_ready, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, acc, has_last, exp_run;
        int w0, len, exp_wc;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", in_ready, 0);
        chk("idle_core_rst", core_rst, 1);
        tick();

        // Single word with in_last.
        do_load();
        @(negedge clk);
        chk("load_ready", in_ready, 1);
        chk("load_busy", busy, 1);
        chk("load_core_rst_on", core_rst, 1);
        tick();
        w0 = n_writes;
        send_word(32'h00100113, 1'b1, 0, 20, 1'b0, acc);
        chk("single_acc", acc, 1);
        wait_drain(ok);
        chk("single_drain", ok, 1);
        @(negedge clk);
        check_end("single", 1'b1, 1);
        chk("single_writes", n_writes - w0, 1);
        tick();

        // Reload straight from RUN.
        do_load();
        @(negedge clk);
        chk("reload_core_rst", core_rst, 1);
        chk("reload_done", done, 0);
        chk("reload_wc", word_count, 0);
        chk("reload_addr", dbg_addr, BASE);
        chk("reload_ready", in_ready, 1);
        tick();
        send_word(32'h00200093, 1'b1, 1, 20, 1'b0, acc);
        chk("reload_acc", acc, 1);
        wait_drain(ok);
        chk("reload_drain", ok, 1);
        @(negedge clk);
        check_end("reload", 1'b1, 1);
        tick();

        // Three words with valid gaps.
        do_load();
        w0 = n_writes;
        send_word(32'h00100113, 1'b0, 2, 20, 1'b0, acc);
        chk("three_acc0", acc, 1);
        send_word(32'h0010A193, 1'b0, 3, 20, 1'b0, acc);
        chk("three_acc1", acc, 1);
        send_word(32'h00113213, 1'b1, 1, 20, 1'b0, acc);
        chk("three_acc2", acc, 1);
        wait_drain(ok);
        chk("three_drain", ok, 1);
        @(negedge clk);
        check_end("three", 1'b1, 3);
        chk("three_writes", n_writes - w0, 3);
        chk("three_last_addr", dbg_addr, BASE + 64'd8);
        tick();

        // Overflow: five words, no in_last.
        do_load();
        w0 = n_writes;
        for (int i = 0; i < 5; i++) begin
            send_word($urandom, 1'b0, 0, (i < MAXW) ? 20 : 12, 1'b0, acc);
            chk("ovf_accept", acc, i < MAXW);
        end
        wait_drain(ok);
        chk("ovf_drain", ok, 1);
        @(negedge clk);
        check_end("ovf", 1'b0, MAXW);
        chk("ovf_writes", n_writes - w0, MAXW);
        tick();
        do_load();
        @(negedge clk);
        chk("ovf_clear", overflow_err, 0);
        chk("ovf_restart_addr", dbg_addr, BASE);
        chk("ovf_restart_ready", in_ready, 1);
        tick();
        send_word(32'hDEADBEEF, 1'b1, 0, 20, 1'b0, acc);
        chk("ovf_restart_acc", acc, 1);
        wait_drain(ok);
        chk("ovf_restart_drain", ok, 1);
        @(negedge clk);
        check_end("ovf_restart", 1'b1, 1);
        tick();

        // Reset one cycle after the second handshake: word 2 is never written.
        do_load();
        send_word(32'h11111111, 1'b0, 0, 20, 1'b0, acc);
        chk("mid_acc0", acc, 1);
        send_word(32'h22222222, 1'b0, 0, 20, 1'b0, acc);
        chk("mid_acc1", acc, 1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        w0 = n_writes;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid");
        repeat (4) @(negedge clk);
        chk("mid_no_write", n_writes - w0, 0);
        tick();

        // Randomized programs against the model.
        for (int r = 0; r < 10; r++) begin
            has_last = 1'($urandom_range(0, 1));
            if (has_last) len = ($urandom_range(0, 3) == 0) ? MAXW + 1 : $urandom_range(1, MAXW);
            else          len = MAXW + 1;
            exp_run = has_last && (len <= MAXW);
            exp_wc  = exp_run ? len : MAXW;
            do_load();
            w0 = n_writes;
            for (int i = 0; i < len; i++) begin
                send_word($urandom, has_last && (i == len - 1), $urandom_range(0, 3),
                          (i < MAXW) ? 40 : 12, i < MAXW, acc);
                chk("rand_accept", acc, i < MAXW);
                if (!acc) break;
            end
            wait_drain(ok);
            chk("rand_drain", ok, 1);
            @(negedge clk);
            check_end("rand", exp_run, exp_wc);
            chk("rand_writes", n_writes - w0, exp_wc);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Controller that sequences the cpuCore debug instruction-write port (dbg_wr_en / dbg_addr / dbg_instr) from a valid/ready instruction stream.
- Holds the core in reset while the program is written, then releases it.
- Sits between a host/boot source (UART bridge, JTAG shim, bench driver) and cpuCore.
- Replaces hand-timed debug writes with a fixed, checked sequence.

Parameters:
- XLEN, 64: address width of dbg_addr.
- INSTRUCTION_LENGTH, XLEN/2: instruction word width.
- BASE_ADDR, 0: byte address of the first instruction written.
- MAX_WORDS, 1024: capacity of instruction memory in words; exceeding it is an error.
- SETTLE_CYCLES, 2: cycles dbg_addr/dbg_instr are held stable before the write strobe (0 allowed).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. Synchronous to clk, active-high: state is reset on the rising edge of clk while rst=1.
- load_start  in  1  begin a (re)load; sampled only in IDLE, RUN, ERROR.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- in_instr  in  INSTRUCTION_LENGTH  instruction word.
- in_last  in  1  marks the final word of the program; qualified by in_valid.
- dbg_wr_en  out  1  instruction memory write strobe to cpuCore.
- dbg_addr  out  XLEN  byte write address.
- dbg_instr  out  INSTRUCTION_LENGTH  write data.
- core_rst  out  1  reset to cpuCore, active-high.
- busy  out  1  high in ACCEPT, SETTLE, WRITE.
- done  out  1  program loaded, core running.
- overflow_err  out  1  program exceeded MAX_WORDS.
- word_count  out  $clog2(MAX_WORDS+1)  words written in the current load.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, core_rst=1, dbg_wr_en=0, dbg_addr=BASE_ADDR, dbg_instr=0, in_ready=0, busy=0, done=0, overflow_err=0, word_count=0.
- Reset mid-operation: all outputs return to reset values on the next edge. A word already handshaken but not yet written is dropped. Memory already written is not undone.
- IDLE:
  - core_rst=1.
  - load_start -> ACCEPT; clear word_count, done and overflow_err; dbg_addr=BASE_ADDR.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: latch in_instr into dbg_instr and latch in_last internally.
  - Then go to SETTLE if SETTLE_CYCLES>0, else directly to WRITE.
- SETTLE:
  - in_ready=0; dbg_addr and dbg_instr held constant.
  - Down-counter runs for exactly SETTLE_CYCLES cycles, then -> WRITE.
- WRITE:
  - dbg_wr_en=1 for exactly one cycle; word_count increments by 1.
  - Next state priority:
    - latched last=1 -> RUN.
    - else word_count (after increment) == MAX_WORDS -> ERROR.
    - else dbg_addr += 4 -> ACCEPT.
- RUN:
  - core_rst=0, done=1, in_ready=0.
  - core_rst falls in the cycle immediately after the final dbg_wr_en pulse.
  - load_start -> ACCEPT, with core_rst=1 and done=0 in the same next cycle; word_count and dbg_addr restart as from IDLE.
- ERROR:
  - overflow_err=1, core_rst=1, in_ready=0.
  - Only load_start (-> ACCEPT, clears overflow_err) or rst exits.
- Invariants:
  - in_ready and dbg_wr_en are never high in the same cycle.
  - dbg_addr/dbg_instr never change while dbg_wr_en=1, nor during SETTLE.
  - load_start is ignored in ACCEPT, SETTLE, WRITE.
- Per-word throughput is 2+SETTLE_CYCLES cycles minimum (handshake, settle, write); an in_valid stall extends ACCEPT indefinitely.
- Single-word program (in_last on first word) is legal.
- dbg_addr arithmetic is modulo 2^XLEN. Wrap is only reachable with BASE_ADDR near the top; no special handling.
- in_last on the MAX_WORDS-th word: last wins, -> RUN, no error.

Test Plan:
1. Reset: assert rst 2 cycles -> core_rst=1, dbg_wr_en=0, dbg_addr=0, in_ready=0, done=0, overflow_err=0, word_count=0.
2. Single word, SETTLE_CYCLES=2:
   - Stimulus: load_start; send 0x00100113 with in_last at handshake cycle T.
   - Required: dbg_wr_en=1 only at T+3 with dbg_addr=0, dbg_instr=0x00100113.
   - Required at T+4: core_rst=0, done=1, word_count=1.
3. Three words with in_valid gaps:
   - Stimulus: ADDI 0x00100113, SLTI 0x0010A193, SLTIU 0x00113213 (last).
   - Required: writes at addresses 0, 4, 8 with matching data, exactly 3 dbg_wr_en pulses.
   - Required: in_ready=0 throughout every SETTLE/WRITE cycle; core_rst low only after the third pulse.
4. Overflow, MAX_WORDS=4:
   - Stimulus: send 5 words without in_last.
   - Required: 4 writes at 0, 4, 8, 12, then overflow_err=1, core_rst=1, in_ready=0; 5th word never accepted.
   - Required: load_start clears overflow_err and restarts at address 0.
5. Reset mid-load: assert rst one cycle after the 2nd handshake -> no dbg_wr_en for word 2; all outputs at reset values next cycle.
6. Reload from RUN:
   - Stimulus: after scenario 2, pulse load_start.
   - Required: core_rst=1 and done=0 next cycle; new word written at address 0; word_count=1 at completion.
